// File: rtl/inst_align_queue.sv
// Instruction alignment queue: splits word-aligned fetch words into RV32C/RV32I
// instructions, including 32-bit instructions that straddle two fetch words.
module inst_align_queue #(
   parameter int unsigned DEPTH         = 8,
   parameter bit          COMPRESSED_EN = 1'b1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     flush,
   input  logic [31:0]              flush_pc,
   input  logic                     fetch_valid,
   input  logic [31:0]              fetch_addr,
   input  logic [31:0]              fetch_word,
   output logic                     fetch_ready,
   output logic                     out_valid,
   output logic [31:0]              out_inst,
   output logic [31:0]              out_addr,
   output logic                     out_is_c,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      addr_mem [DEPTH];
   logic [DEPTH-1:0] c_mem;

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] tail_p1;
   logic [31:0]   exp_pc;
   logic          ph_valid;
   logic [15:0]   ph_data;
   logic [31:0]   ph_addr;

   logic          accept;
   logic          match;
   logic          deq;
   logic [15:0]   lo;
   logic [15:0]   hi;
   logic          lo_c;
   logic          hi_c;
   logic          proc_hi;
   logic [1:0]    n_enq;
   logic [1:0]    n_push;
   logic [31:0]   e0_inst;
   logic [31:0]   e0_addr;
   logic          e0_c;
   logic [31:0]   e1_inst;
   logic [31:0]   e1_addr;
   logic          e1_c;
   logic          ph_valid_n;
   logic [15:0]   ph_data_n;
   logic [31:0]   ph_addr_n;
   logic          unused_exp_pc0;

   assign unused_exp_pc0 = exp_pc[0];

   // Handshake qualification and stale-word detection
   always_comb begin
      fetch_ready = (count <= CW'(DEPTH - 2));
      accept      = fetch_valid && fetch_ready && rdy_in && !flush;
      match       = accept && (fetch_addr == {exp_pc[31:2], 2'b00});
      deq         = out_valid && out_ready && rdy_in && !flush;
      tail_p1     = tail + PW'(1'b1);
      lo          = fetch_word[15:0];
      hi          = fetch_word[31:16];
      lo_c        = (lo[1:0] != 2'b11);
      hi_c        = (hi[1:0] != 2'b11);
   end

   // Split the fetch word into up to two entries in address order
   always_comb begin
      n_enq      = 2'd0;
      proc_hi    = 1'b0;
      e0_inst    = '0;
      e0_addr    = '0;
      e0_c       = 1'b0;
      e1_inst    = '0;
      e1_addr    = '0;
      e1_c       = 1'b0;
      ph_valid_n = ph_valid;
      ph_data_n  = ph_data;
      ph_addr_n  = ph_addr;
      if (!COMPRESSED_EN) begin
         e0_inst = fetch_word;
         e0_addr = fetch_addr;
         n_enq   = 2'd1;
      end else begin
         proc_hi = 1'b1;
         if (ph_valid) begin
            e0_inst    = {lo, ph_data};
            e0_addr    = ph_addr;
            n_enq      = 2'd1;
            ph_valid_n = 1'b0;
         end else if (exp_pc[1]) begin
            proc_hi = 1'b1;
         end else if (lo_c) begin
            e0_inst = {16'b0, lo};
            e0_addr = fetch_addr;
            e0_c    = 1'b1;
            n_enq   = 2'd1;
         end else begin
            e0_inst = fetch_word;
            e0_addr = fetch_addr;
            n_enq   = 2'd1;
            proc_hi = 1'b0;
         end
         if (proc_hi) begin
            if (hi_c) begin
               if (n_enq == 2'd0) begin
                  e0_inst = {16'b0, hi};
                  e0_addr = fetch_addr + 32'd2;
                  e0_c    = 1'b1;
               end else begin
                  e1_inst = {16'b0, hi};
                  e1_addr = fetch_addr + 32'd2;
                  e1_c    = 1'b1;
               end
               n_enq = n_enq + 2'd1;
            end else begin
               ph_valid_n = 1'b1;
               ph_data_n  = hi;
               ph_addr_n  = fetch_addr + 32'd2;
            end
         end
      end
      n_push = match ? n_enq : 2'd0;
   end

   // Pointers, occupancy, expected PC and pending halfword
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         exp_pc   <= '0;
         ph_valid <= 1'b0;
         ph_data  <= '0;
         ph_addr  <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            exp_pc   <= flush_pc;
            ph_valid <= 1'b0;
         end else begin
            if (match) begin
               tail     <= tail + PW'(n_enq);
               exp_pc   <= fetch_addr + 32'd4;
               ph_valid <= ph_valid_n;
               ph_data  <= ph_data_n;
               ph_addr  <= ph_addr_n;
            end
            if (deq) begin
               head <= head + PW'(1'b1);
            end
            count <= count + CW'(n_push) - CW'(deq);
         end
      end
   end

   // Queue storage; contents need no reset since out_* is gated by occupancy
   always_ff @(posedge clk_in) begin
      if (match) begin
         if (n_enq != 2'd0) begin
            inst_mem[tail] <= e0_inst;
            addr_mem[tail] <= e0_addr;
            c_mem[tail]    <= e0_c;
         end
         if (n_enq == 2'd2) begin
            inst_mem[tail_p1] <= e1_inst;
            addr_mem[tail_p1] <= e1_addr;
            c_mem[tail_p1]    <= e1_c;
         end
      end
   end

   always_comb begin
      out_valid = (count != '0);
      out_inst  = out_valid ? inst_mem[head] : '0;
      out_addr  = out_valid ? addr_mem[head] : '0;
      out_is_c  = out_valid ? c_mem[head] : 1'b0;
      empty     = (count == '0);
      full      = (count == CW'(DEPTH));
   end

endmodule

// File: tb/tb_inst_align_queue.sv
// Bench for inst_align_queue: directed scenarios plus randomized traffic, all
// checked against a halfword-stream reference model.
module tb_inst_align_queue;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush;
   logic [31:0] flush_pc;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_word;
   logic        fetch_ready;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_addr;
   logic        out_is_c;
   logic        out_ready;
   logic [3:0]  count;
   logic        empty;
   logic        full;

   logic        nc_fetch_valid;
   logic [31:0] nc_fetch_addr;
   logic [31:0] nc_fetch_word;
   logic        nc_fetch_ready;
   logic        nc_out_valid;
   logic [31:0] nc_out_inst;
   logic [31:0] nc_out_addr;
   logic        nc_out_is_c;
   logic        nc_out_ready;
   logic [3:0]  nc_count;
   logic        nc_empty;
   logic        nc_full;

   always #5 clk_in = ~clk_in;

   inst_align_queue #(.DEPTH(8), .COMPRESSED_EN(1'b1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .flush_pc(flush_pc),
      .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_word(fetch_word),
      .fetch_ready(fetch_ready), .out_valid(out_valid), .out_inst(out_inst), .out_addr(out_addr),
      .out_is_c(out_is_c), .out_ready(out_ready), .count(count), .empty(empty), .full(full)
   );

   inst_align_queue #(.DEPTH(8), .COMPRESSED_EN(1'b0)) dut_nc (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .flush_pc(flush_pc),
      .fetch_valid(nc_fetch_valid), .fetch_addr(nc_fetch_addr), .fetch_word(nc_fetch_word),
      .fetch_ready(nc_fetch_ready), .out_valid(nc_out_valid), .out_inst(nc_out_inst),
      .out_addr(nc_out_addr), .out_is_c(nc_out_is_c), .out_ready(nc_out_ready),
      .count(nc_count), .empty(nc_empty), .full(nc_full)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        is_c;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
   } half_t;

   ent_t        iq[$];
   half_t       hb[$];
   logic [31:0] m_exp;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Reference: the accepted fetch stream is a sequence of halfwords; each
   // instruction is carved off the front by its length bits.
   task automatic model_word(input logic [31:0] addr, input logic [31:0] word);
      half_t h;
      ent_t  e;
      if (hb.size() != 0 || !m_exp[1]) begin
         h.addr = addr; h.data = word[15:0]; hb.push_back(h);
      end
      h.addr = addr + 32'd2; h.data = word[31:16]; hb.push_back(h);
      while (hb.size() != 0) begin
         if (hb[0].data[1:0] != 2'b11) begin
            e.inst = {16'b0, hb[0].data}; e.addr = hb[0].addr; e.is_c = 1'b1;
            iq.push_back(e);
            void'(hb.pop_front());
         end else if (hb.size() >= 2) begin
            e.inst = {hb[1].data, hb[0].data}; e.addr = hb[0].addr; e.is_c = 1'b0;
            iq.push_back(e);
            void'(hb.pop_front());
            void'(hb.pop_front());
         end else begin
            break;
         end
      end
      m_exp = addr + 32'd4;
   endtask

   task automatic check_all();
      check("fetch_ready", fetch_ready, (8 - iq.size() >= 2));
      check("count", count, iq.size());
      check("empty", empty, iq.size() == 0);
      check("full", full, iq.size() == 8);
      check("out_valid", out_valid, iq.size() != 0);
      if (iq.size() != 0) begin
         check("out_inst", out_inst, iq[0].inst);
         check("out_addr", out_addr, iq[0].addr);
         check("out_is_c", out_is_c, iq[0].is_c);
      end
   endtask

   // One clock: drive after a falling edge, update the model, check at the next falling edge
   task automatic step(input logic fv, input logic [31:0] fa, input logic [31:0] fw,
                       input logic ordy, input logic fl, input logic [31:0] fpc, input logic rdy);
      logic fr;
      fetch_valid = fv; fetch_addr = fa; fetch_word = fw;
      out_ready = ordy; flush = fl; flush_pc = fpc; rdy_in = rdy;
      fr = (8 - iq.size() >= 2);
      if (rdy) begin
         if (fl) begin
            iq.delete(); hb.delete(); m_exp = fpc;
         end else begin
            if (ordy && iq.size() != 0) void'(iq.pop_front());
            if (fv && fr && fa == {m_exp[31:2], 2'b00}) model_word(fa, fw);
         end
      end
      @(negedge clk_in);
      check_all();
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic do_flush(input logic [31:0] pc);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, pc, 1'b1);
   endtask

   task automatic feed(input logic [31:0] a, input logic [31:0] w);
      step(1'b1, a, w, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic expect_head(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                              input logic c);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_inst"}, out_inst, inst);
      check({tag, "_addr"}, out_addr, addr);
      check({tag, "_is_c"}, out_is_c, c);
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      return h;
   endfunction

   initial begin
      logic [31:0] held_addr;
      logic [3:0]  held_count;
      m_exp = 32'h0;
      rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; flush_pc = '0;
      fetch_valid = 1'b0; fetch_addr = '0; fetch_word = '0; out_ready = 1'b0;
      nc_fetch_valid = 1'b0; nc_fetch_addr = '0; nc_fetch_word = '0; nc_out_ready = 1'b0;
      repeat (2) @(negedge clk_in);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_out_addr", out_addr, 32'h0);
      check("rst_out_is_c", out_is_c, 1'b0);
      check("rst_count", count, 4'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_fetch_ready", fetch_ready, 1'b1);
      rst_in = 1'b1;
      @(negedge clk_in);

      // Aligned 32-bit word
      do_flush(32'h0);
      feed(32'h0, 32'h0000_0013);
      expect_head("t1", 32'h0000_0013, 32'h0, 1'b0);
      idle(1'b1);
      check("t1_count_drained", count, 4'd0);

      // Two compressed in one word
      do_flush(32'h0);
      feed(32'h0, 32'h4501_4501);
      check("t2_count", count, 4'd2);
      expect_head("t2a", 32'h0000_4501, 32'h0, 1'b1);
      idle(1'b1);
      expect_head("t2b", 32'h0000_4501, 32'h2, 1'b1);
      idle(1'b1);

      // Straddling 32-bit instruction
      do_flush(32'h0);
      feed(32'h0, 32'h0013_4501);
      check("t3_count1", count, 4'd1);
      feed(32'h4, 32'h4501_0000);
      check("t3_count2", count, 4'd3);
      expect_head("t3a", 32'h0000_4501, 32'h0, 1'b1);
      idle(1'b1);
      expect_head("t3b", 32'h0000_0013, 32'h2, 1'b0);
      idle(1'b1);
      expect_head("t3c", 32'h0000_4501, 32'h6, 1'b1);
      idle(1'b1);

      // Flush with odd restart address
      do_flush(32'h0);
      feed(32'h0, 32'h4501_4501);
      feed(32'h4, 32'h0000_0013);
      check("t4_count_pre", count, 4'd3);
      do_flush(32'h102);
      check("t4_count_flush", count, 4'd0);
      check("t4_valid_flush", out_valid, 1'b0);
      feed(32'h8, 32'h4501_4501);
      check("t4_stale_dropped", count, 4'd0);
      feed(32'h100, 32'h4501_0013);
      check("t4_count", count, 4'd1);
      expect_head("t4", 32'h0000_4501, 32'h102, 1'b1);
      idle(1'b1);

      // Backpressure and rdy_in hold
      do_flush(32'h0);
      for (int i = 0; i < 5; i++) feed(32'(i * 4), 32'h4501_4501);
      check("t5_full", full, 1'b1);
      check("t5_fr_at8", fetch_ready, 1'b0);
      step(1'b1, 32'h10, 32'h4501_4501, 1'b1, 1'b0, 32'h0, 1'b1);
      check("t5_count7", count, 4'd7);
      check("t5_fr_at7", fetch_ready, 1'b0);
      held_addr = out_addr; held_count = count;
      for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 32'h4501_4501, 1'b1, 1'b0, 32'h0, 1'b0);
      check("t5_hold_count", count, held_count);
      check("t5_hold_addr", out_addr, held_addr);
      idle(1'b1);
      feed(32'h10, 32'h4501_4501);
      check("t5_exp_pc_kept", count, 4'd8);
      for (int i = 0; i < 8; i++) idle(1'b1);

      // Non-compressed configuration
      do_flush(32'h0);
      nc_fetch_valid = 1'b1; nc_fetch_addr = 32'h0; nc_fetch_word = 32'h4501_4501;
      idle(1'b0);
      nc_fetch_addr = 32'h4; nc_fetch_word = 32'h0000_0013;
      check("nc_valid", nc_out_valid, 1'b1);
      check("nc_inst", nc_out_inst, 32'h4501_4501);
      check("nc_addr", nc_out_addr, 32'h0);
      check("nc_is_c", nc_out_is_c, 1'b0);
      check("nc_count1", nc_count, 4'd1);
      idle(1'b0);
      nc_fetch_valid = 1'b0; nc_out_ready = 1'b1;
      check("nc_count2", nc_count, 4'd2);
      idle(1'b0);
      nc_out_ready = 1'b0;
      check("nc_inst2", nc_out_inst, 32'h0000_0013);
      check("nc_addr2", nc_out_addr, 32'h4);
      check("nc_count3", nc_count, 4'd1);

      // Randomized traffic
      do_flush(32'h0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        fv, ordy, fl, rdy;
         logic [31:0] fa, fw, fpc;
         fl   = ($urandom_range(0, 99) < 3);
         rdy  = ($urandom_range(0, 9) != 0);
         ordy = ($urandom_range(0, 99) < 45);
         fv   = ($urandom_range(0, 9) < 7);
         fpc  = 32'($urandom_range(0, 2047)) << 1;
         fa   = ($urandom_range(0, 9) < 8) ? {m_exp[31:2], 2'b00} : (32'($urandom_range(0, 1023)) << 2);
         fw   = {rand_half(), rand_half()};
         step(fv, fa, fw, ordy, fl, fpc, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_align_queue.md
# inst_align_queue

Parametrised instruction alignment queue between the instruction fetcher and the decoder. It accepts word-aligned 32-bit fetch words, splits them into RV32C (16-bit) and RV32I (32-bit) instructions, including 32-bit instructions that straddle two fetch words, and buffers them in a DEPTH-entry circular queue. It presents one instruction per cycle to the decoder with a valid/ready handshake and discards everything on a misprediction flush.

## Interface
- DEPTH, 8: queue entries; power of two, minimum 4.
- COMPRESSED_EN, 1: 1 = RV32IC splitting; 0 = every fetch word is one 32-bit instruction, and the pending-halfword logic is unused.
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- rdy_in  input  1  global ready; when low, all state holds and no handshake completes
- flush  input  1  misprediction flush from ROB
- flush_pc  input  32  restart address, halfword aligned (bit 1 must be 0 when COMPRESSED_EN=0)
- fetch_valid  input  1  fetch word valid
- fetch_addr  input  32  fetch word address, bits[1:0]=0
- fetch_word  input  32  fetch data; low halfword at fetch_addr, high halfword at fetch_addr+2
- fetch_ready  output  1  queue accepts a word this cycle
- out_valid  output  1  head entry valid
- out_inst  output  32  head instruction; compressed entries are zero-extended to {16'b0, half}
- out_addr  output  32  head instruction address
- out_is_c  output  1  head entry is a 16-bit instruction
- out_ready  input  1  decoder consumes the head (issue)
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count==0
- full  output  1  count==DEPTH

## Operation
- State:
  - queue RAM, head, tail, count
  - exp_pc (next expected halfword address)
  - pending halfword: ph_valid, ph_data[15:0], ph_addr
- A fetch word is accepted when fetch_valid && fetch_ready && rdy_in && !flush.
- An accepted word with fetch_addr != {exp_pc[31:2],2'b00} is stale: it is dropped, and no state changes.
- Splitting a matching word, with lo = bits[15:0] and hi = bits[31:16]. A half is compressed iff half[1:0] != 2'b11.
  - If ph_valid: enqueue {lo, ph_data} at ph_addr (32-bit) and clear ph_valid. Then process hi.
  - Else if exp_pc[1]==1: skip lo and process hi.
  - Else if lo is compressed: enqueue lo at fetch_addr, then process hi.
  - Else: enqueue the whole word at fetch_addr (32-bit). hi is consumed.
  - Processing hi: if compressed, enqueue it at fetch_addr+2; otherwise load pending with ph_data=hi, ph_addr=fetch_addr+2.
- Each accepted word produces 0–2 enqueues, written in address order at tail and tail+1.
- exp_pc <= fetch_addr+4 after every accepted matching word.
- COMPRESSED_EN=0: each matching word gives exactly one 32-bit enqueue. out_is_c is always 0.
- Dequeue when out_valid && out_ready && rdy_in: head advances by 1.
- count updates by (enqueues − dequeue) in the same cycle. Pointers wrap modulo DEPTH.
- Flush (rdy_in high) has the highest priority. It:
  - sets head=tail=count=0 and ph_valid=0, and sets exp_pc=flush_pc;
  - ignores any fetch word and dequeue in that cycle.
- Reset (rst_in low, any time, asynchronous): queue empty, ph_valid=0, exp_pc=0, head=tail=0.

## Timing
- Reset values: out_valid=0, out_inst=0, out_addr=0, out_is_c=0, count=0, empty=1, full=0. fetch_ready is 1 once rdy_in is high.
- fetch_ready = (DEPTH − count ≥ 2). It uses the registered count only; a same-cycle dequeue does not add space.
- out_* are combinational from the head entry. out_valid = (count != 0).
- There is no fetch-to-output bypass. An instruction enqueued in cycle N is visible at out_* in cycle N+1 at the earliest.
- After a flush in cycle N: out_valid=0 in N+1. The first valid output needs a matching word accepted in N+1 or later.
- While rdy_in is low: registers hold, and out_* and count stay stable.
- A pending halfword survives any number of idle cycles until the next matching word arrives or a flush occurs.

## Test plan
1. Aligned 32-bit:
   - Stimulus: reset, flush_pc=0x0, then word 0x00000013 at 0x0.
   - Required: next cycle out_valid=1, out_inst=0x00000013, out_addr=0x0, out_is_c=0. count returns to 0 after out_ready.
2. Two compressed in one word:
   - Stimulus: word 0x45014501 at 0x0.
   - Required: entries 0x00004501@0x0 and 0x00004501@0x2, both out_is_c=1, count=2.
3. Straddle:
   - Stimulus: word 0x00134501 at 0x0, then word 0x45010000 at 0x4.
   - Required: outputs in order 0x4501@0x0, 0x00000013@0x2, 0x4501@0x6.
4. Flush and odd restart:
   - Stimulus: queue holding 3 entries; flush with flush_pc=0x102; then a stale word at 0x8, then word 0x45010013 at 0x100.
   - Required: count=0 next cycle; stale word dropped; only 0x00004501@0x102 emitted.
5. Backpressure and rdy_in:
   - Stimulus: DEPTH=8, out_ready=0, stream of compressed-pair words.
   - Required: fetch_ready=0 once count=7 or 8; full=1 at 8.
   - Also: rdy_in=0 for 3 cycles mid-stream leaves count, out_* and exp_pc unchanged.
6. COMPRESSED_EN=0:
   - Stimulus: word 0x45014501 at 0x0.
   - Required: one entry, out_inst=0x45014501, out_is_c=0, count=1.
